demux_c: RTL and testbench
==========================

Name: demux_c

Overview:
1:2 demultiplexer, the receive-side counterpart of the team's registered 2:1 mux.
- Steers a single WIDTH-bit valid/ready input stream onto one of two output lanes.
- Each lane has a one-entry registered holding stage with its own valid/ready handshake.
- Lane is chosen by an external select or by an internal alternating (round-robin) pointer.
- Per-lane delivery counters for link bring-up and debug.

Parameters:
WIDTH, 8, data width of input and each lane
CW, 8, width of per-lane delivered-word counters

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
data_in  input  WIDTH  input word
valid_in  input  1  data_in valid
ready_out  output  1  demux can accept this cycle
sel  input  1  external lane select (0 = lane 0, 1 = lane 1), used when alt_en=0
alt_en  input  1  1 = use internal alternating pointer, 0 = use sel
data_out_0  output  WIDTH  lane 0 data (registered)
valid_out_0  output  1  lane 0 holds a word
ready_in_0  input  1  lane 0 sink accepts
data_out_1  output  WIDTH  lane 1 data (registered)
valid_out_1  output  1  lane 1 holds a word
ready_in_1  input  1  lane 1 sink accepts
cnt_0  output  CW  words delivered on lane 0
cnt_1  output  CW  words delivered on lane 1

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0: data_out_*, valid_out_*, cnt_*, ready_out.
  - Internal pointer ptr=0.
  - Pending words are discarded.
- After reset release: state takes effect from the first rising edge.
- Effective select: eff = alt_en ? ptr : sel, evaluated combinationally in the accept cycle.
- Lane state machine, one instance per lane, state equals valid_out_n:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain+load (reload) or on no drain.
- drain_n = valid_out_n & ready_in_n.
- lane_free_n = !valid_out_n | drain_n.
- ready_out = lane_free_eff, combinational from registered state and ready_in_eff; never depends on valid_in.
- accept = valid_in & ready_out.
  - On accept, data_in loads into lane eff at the edge; valid_out_eff=1 the next cycle.
  - Latency is 1 cycle input to lane output.
- Non-selected lane is never written. Its data_out holds its value, even when EMPTY.
- ptr toggles on every accept while alt_en=1.
  - ptr holds while alt_en=0, and resumes from its held value when alt_en returns to 1.
- Simultaneous drain and load on the same lane: new word loads, valid stays 1, no bubble.
  - Full throughput is 1 word/cycle when the selected sink is always ready.
- Selected lane FULL and not draining: ready_out=0, input stalls. The other lane still drains independently.
- sel or alt_en changing while valid_in=1 and ready_out=0 is legal. The word goes to the lane selected in the accept cycle.
- cnt_n increments on drain_n and wraps 2^CW-1 -> 0.
- No data loss or duplication: every accepted word produces exactly one drain handshake, barring reset.

Decomposition:
- Package demux_c_pkg:
  - LANE0=1'b0, LANE1=1'b1.
  - Lane state encoding ST_EMPTY=1'b0, ST_FULL=1'b1.
  - Default WIDTH/CW constants.
- Sub-module demux_c_lane: one-entry holding register with load/drain handshake, lane_free output and delivered counter. Instantiated twice.
- Top holds ptr, select logic and ready_out.

Test Plan:
1. Reset check: assert reset=0 mid-stream with both lanes FULL -> outputs, cnt_0, cnt_1 read 0 and ready_out reads 0 immediately, without a clock edge. After release with both sinks ready, ready_out=1.
2. External select, alt_en=0, both sinks ready: send 0xA1 (sel=0), 0xB2 (sel=1), 0xC3 (sel=0) back-to-back.
   - Lane 0 shows 0xA1 then 0xC3.
   - Lane 1 shows 0xB2.
   - Each word appears 1 cycle after accept.
   - cnt_0=2, cnt_1=1.
3. Alternating mode, alt_en=1, both sinks ready: send 0x10..0x17 continuously.
   - Lane 0 gets 0x10,0x12,0x14,0x16; lane 1 gets 0x11,0x13,0x15,0x17.
   - ready_out stays 1 throughout.
4. Backpressure, alt_en=0, sel=1, ready_in_1=0: send 0x55, then 0x66.
   - 0x55 is held on lane 1; ready_out drops to 0 while 0x66 waits.
   - Raise ready_in_1 -> 0x55 drains and 0x66 loads in the same edge; valid_out_1 stays 1.
   - Lane 0 is untouched.
5. Independent drain: lane 0 FULL with ready_in_0=1, input stalled on a full lane 1 -> lane 0 drains and cnt_0 increments while ready_out=0.
6. Counter wrap, CW=4: deliver 17 words on lane 0 -> cnt_0 = 1.

Source files
------------

// File: rtl/demux_c_pkg.sv
// Shared constants for the demux_c 1:2 stream demultiplexer.
// Lane identifiers, lane state encoding and default widths.
package demux_c_pkg;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } lane_st_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CW    = 8;

endpackage

// File: rtl/demux_c_lane.sv
// One demux output lane: single-entry holding register with valid/ready handshake
// and a wrapping delivered-word counter.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_EMPTY | no word held; valid_o=0, data_o keeps the last word
// ST_FULL  | word held on data_o; valid_o=1 until the sink takes it
module demux_c_lane
    import demux_c_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             free_o,
    output logic [CW-1:0]    cnt_o
);

    lane_st_e         state_q;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    cnt_q;
    logic             drain;

    assign drain  = (state_q == ST_FULL) && ready_i;
    assign free_o = (state_q == ST_EMPTY) || drain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (load_i) begin
                data_q <= data_i;
            end
            if (drain) begin
                cnt_q <= cnt_q + CW'(1);
            end
            case (state_q)
                ST_EMPTY: begin
                    if (load_i) begin
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // drain with a simultaneous load stays FULL: no bubble
                    if (drain && !load_i) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign data_o  = data_q;
    assign valid_o = (state_q == ST_FULL);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux_c.sv
// 1:2 valid/ready demultiplexer: steers the input stream to lane 0 or 1 chosen
// by an external select or an alternating pointer; each lane is a registered stage.
module demux_c
    import demux_c_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             sel,
    input  logic             alt_en,
    output logic [WIDTH-1:0] data_out_0,
    output logic             valid_out_0,
    input  logic             ready_in_0,
    output logic [WIDTH-1:0] data_out_1,
    output logic             valid_out_1,
    input  logic             ready_in_1,
    output logic [CW-1:0]    cnt_0,
    output logic [CW-1:0]    cnt_1
);

    logic ptr_q;
    logic eff;
    logic free_0;
    logic free_1;
    logic accept;
    logic load_0;
    logic load_1;

    assign eff = alt_en ? ptr_q : sel;

    // reset term keeps ready_out low while reset is held, even though lanes read free
    assign ready_out = reset && ((eff == LANE1) ? free_1 : free_0);
    assign accept    = valid_in && ready_out;
    assign load_0    = accept && (eff == LANE0);
    assign load_1    = accept && (eff == LANE1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= LANE0;
        end else if (accept && alt_en) begin
            ptr_q <= ~ptr_q;
        end
    end

    demux_c_lane #(.WIDTH(WIDTH), .CW(CW)) u_lane_0 (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load_0),
        .data_i  (data_in),
        .ready_i (ready_in_0),
        .data_o  (data_out_0),
        .valid_o (valid_out_0),
        .free_o  (free_0),
        .cnt_o   (cnt_0)
    );

    demux_c_lane #(.WIDTH(WIDTH), .CW(CW)) u_lane_1 (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load_1),
        .data_i  (data_in),
        .ready_i (ready_in_1),
        .data_o  (data_out_1),
        .valid_o (valid_out_1),
        .free_o  (free_1),
        .cnt_o   (cnt_1)
    );

endmodule

// File: tb/tb_demux_c.sv
// Self-checking bench for demux_c: per-lane scoreboard queues filled on accept and
// drained on each lane handshake, plus per-scenario directed checks.
module tb_demux_c;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             valid_in = 1'b0;
    logic             ready_out;
    logic             sel = 1'b0;
    logic             alt_en = 1'b0;
    logic [WIDTH-1:0] data_out_0;
    logic             valid_out_0;
    logic             ready_in_0 = 1'b0;
    logic [WIDTH-1:0] data_out_1;
    logic             valid_out_1;
    logic             ready_in_1 = 1'b0;
    logic [CW-1:0]    cnt_0;
    logic [CW-1:0]    cnt_1;

    int n_checks = 0;
    int n_pass   = 0;

    demux_c #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .sel         (sel),
        .alt_en      (alt_en),
        .data_out_0  (data_out_0),
        .valid_out_0 (valid_out_0),
        .ready_in_0  (ready_in_0),
        .data_out_1  (data_out_1),
        .valid_out_1 (valid_out_1),
        .ready_in_1  (ready_in_1),
        .cnt_0       (cnt_0),
        .cnt_1       (cnt_1)
    );

    always #5 clk = ~clk;

    // reference model of the spec behaviour, evaluated mid-cycle
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic             m_full0 = 1'b0;
    logic             m_full1 = 1'b0;
    logic             m_ptr   = 1'b0;
    logic [CW-1:0]    m_cnt0  = '0;
    logic [CW-1:0]    m_cnt1  = '0;

    always @(negedge clk) begin
        logic m_eff, m_dr0, m_dr1, m_ready, m_acc;
        logic [WIDTH-1:0] exp_w;
        if (!reset) begin
            m_full0 = 1'b0; m_full1 = 1'b0; m_ptr = 1'b0;
            m_cnt0 = '0; m_cnt1 = '0;
            q0.delete(); q1.delete();
            n_checks++;
            if ({ready_out, valid_out_0, valid_out_1} !== 3'b000)
                $display("FAIL mon_reset: got rdy/v0/v1=%b expected 000", {ready_out, valid_out_0, valid_out_1});
            else n_pass++;
        end else begin
            m_eff   = alt_en ? m_ptr : sel;
            m_dr0   = m_full0 & ready_in_0;
            m_dr1   = m_full1 & ready_in_1;
            m_ready = m_eff ? (!m_full1 | m_dr1) : (!m_full0 | m_dr0);
            n_checks++;
            if (ready_out !== m_ready)
                $display("FAIL mon_ready: got %b expected %b", ready_out, m_ready);
            else n_pass++;
            n_checks++;
            if ({valid_out_0, valid_out_1} !== {m_full0, m_full1})
                $display("FAIL mon_valid: got v0/v1=%b expected %b", {valid_out_0, valid_out_1}, {m_full0, m_full1});
            else n_pass++;
            n_checks++;
            if ({cnt_0, cnt_1} !== {m_cnt0, m_cnt1})
                $display("FAIL mon_cnt: got %h/%h expected %h/%h", cnt_0, cnt_1, m_cnt0, m_cnt1);
            else n_pass++;
            if (m_dr0) begin
                exp_w = (q0.size() > 0) ? q0.pop_front() : 'x;
                n_checks++;
                if (data_out_0 !== exp_w)
                    $display("FAIL sb_lane0: got %h expected %h", data_out_0, exp_w);
                else n_pass++;
                m_cnt0 = m_cnt0 + 1'b1;
            end
            if (m_dr1) begin
                exp_w = (q1.size() > 0) ? q1.pop_front() : 'x;
                n_checks++;
                if (data_out_1 !== exp_w)
                    $display("FAIL sb_lane1: got %h expected %h", data_out_1, exp_w);
                else n_pass++;
                m_cnt1 = m_cnt1 + 1'b1;
            end
            m_acc = valid_in & m_ready;
            if (m_acc && !m_eff) q0.push_back(data_in);
            if (m_acc &&  m_eff) q1.push_back(data_in);
            m_full0 = (m_acc & !m_eff) | (m_full0 & !m_dr0);
            m_full1 = (m_acc &  m_eff) | (m_full1 & !m_dr1);
            if (m_acc && alt_en) m_ptr = ~m_ptr;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic s);
        valid_in = v;
        data_in  = d;
        sel      = s;
    endtask

    task automatic test_reset_por;
        #2;
        n_checks++;
        if ({ready_out, valid_out_0, valid_out_1, data_out_0, data_out_1, cnt_0, cnt_1} !== '0)
            $display("FAIL por_outputs: got rdy=%b v=%b%b d=%h/%h c=%h/%h expected all 0",
                     ready_out, valid_out_0, valid_out_1, data_out_0, data_out_1, cnt_0, cnt_1);
        else n_pass++;
        cyc(2);
        ready_in_0 = 1'b1;
        ready_in_1 = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ready_out !== 1'b1) $display("FAIL por_ready: got %b expected 1", ready_out);
        else n_pass++;
    endtask

    task automatic test_external;
        alt_en = 1'b0;
        drive(1'b1, 8'hA1, 1'b0);
        cyc();
        n_checks++;
        if ({valid_out_0, data_out_0} !== {1'b1, 8'hA1})
            $display("FAIL ext_a1: got v=%b d=%h expected v=1 d=a1", valid_out_0, data_out_0);
        else n_pass++;
        drive(1'b1, 8'hB2, 1'b1);
        cyc();
        n_checks++;
        if ({valid_out_1, data_out_1} !== {1'b1, 8'hB2})
            $display("FAIL ext_b2: got v=%b d=%h expected v=1 d=b2", valid_out_1, data_out_1);
        else n_pass++;
        drive(1'b1, 8'hC3, 1'b0);
        cyc();
        n_checks++;
        if ({valid_out_0, data_out_0, valid_out_1, data_out_1} !== {1'b1, 8'hC3, 1'b0, 8'hB2})
            $display("FAIL ext_c3: got v0=%b d0=%h v1=%b d1=%h expected 1 c3 0 b2",
                     valid_out_0, data_out_0, valid_out_1, data_out_1);
        else n_pass++;
        drive(1'b0, 8'h00, 1'b0);
        cyc(2);
        n_checks++;
        if ({cnt_0, cnt_1} !== {4'd2, 4'd1})
            $display("FAIL ext_cnt: got %0d/%0d expected 2/1", cnt_0, cnt_1);
        else n_pass++;
    endtask

    task automatic test_alternating;
        logic [WIDTH-1:0] w;
        alt_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 8'h10 + 8'(i);
            drive(1'b1, w, 1'b0);
            #1;
            n_checks++;
            if (ready_out !== 1'b1) $display("FAIL alt_ready[%0d]: got %b expected 1", i, ready_out);
            else n_pass++;
            cyc();
            n_checks++;
            if ((i % 2) == 0 ? ({valid_out_0, data_out_0} !== {1'b1, w}) : ({valid_out_1, data_out_1} !== {1'b1, w}))
                $display("FAIL alt_lane[%0d]: got d0=%h d1=%h expected %h on lane %0d",
                         i, data_out_0, data_out_1, w, i % 2);
            else n_pass++;
        end
        drive(1'b0, 8'h00, 1'b0);
        cyc(2);
        alt_en = 1'b0;
    endtask

    task automatic test_backpressure;
        ready_in_0 = 1'b1;
        ready_in_1 = 1'b0;
        drive(1'b1, 8'h55, 1'b1);
        cyc();
        drive(1'b1, 8'h66, 1'b1);
        #1;
        n_checks++;
        if ({ready_out, valid_out_1, data_out_1} !== {1'b0, 1'b1, 8'h55})
            $display("FAIL bp_hold: got rdy=%b v1=%b d1=%h expected 0 1 55", ready_out, valid_out_1, data_out_1);
        else n_pass++;
        cyc();
        n_checks++;
        if ({ready_out, data_out_1} !== {1'b0, 8'h55})
            $display("FAIL bp_stall: got rdy=%b d1=%h expected 0 55", ready_out, data_out_1);
        else n_pass++;
        ready_in_1 = 1'b1;
        #1;
        n_checks++;
        if (ready_out !== 1'b1) $display("FAIL bp_release: got rdy=%b expected 1", ready_out);
        else n_pass++;
        cyc();
        drive(1'b0, 8'h00, 1'b1);
        n_checks++;
        if ({valid_out_1, data_out_1} !== {1'b1, 8'h66})
            $display("FAIL bp_reload: got v1=%b d1=%h expected 1 66", valid_out_1, data_out_1);
        else n_pass++;
        n_checks++;
        if ({valid_out_0, data_out_0} !== {1'b0, 8'h16})
            $display("FAIL bp_lane0: got v0=%b d0=%h expected 0 16", valid_out_0, data_out_0);
        else n_pass++;
        cyc(2);
    endtask

    task automatic test_independent;
        ready_in_0 = 1'b0;
        ready_in_1 = 1'b0;
        drive(1'b1, 8'h77, 1'b0);
        cyc();
        drive(1'b1, 8'h88, 1'b1);
        cyc();
        drive(1'b1, 8'h99, 1'b1);
        ready_in_0 = 1'b1;
        #1;
        n_checks++;
        if (ready_out !== 1'b0) $display("FAIL ind_stall: got rdy=%b expected 0", ready_out);
        else n_pass++;
        cyc();
        n_checks++;
        if ({valid_out_0, cnt_0, ready_out, valid_out_1, data_out_1} !== {1'b0, 4'd7, 1'b0, 1'b1, 8'h88})
            $display("FAIL ind_drain: got v0=%b c0=%0d rdy=%b v1=%b d1=%h expected 0 7 0 1 88",
                     valid_out_0, cnt_0, ready_out, valid_out_1, data_out_1);
        else n_pass++;
        // retarget the stalled word to the now-empty lane 0
        sel = 1'b0;
        #1;
        n_checks++;
        if (ready_out !== 1'b1) $display("FAIL ind_resel: got rdy=%b expected 1", ready_out);
        else n_pass++;
        cyc();
        drive(1'b0, 8'h00, 1'b0);
        n_checks++;
        if ({valid_out_0, data_out_0, valid_out_1} !== {1'b1, 8'h99, 1'b1})
            $display("FAIL ind_load: got v0=%b d0=%h v1=%b expected 1 99 1", valid_out_0, data_out_0, valid_out_1);
        else n_pass++;
        ready_in_1 = 1'b1;
        cyc(3);
    endtask

    task automatic test_reset_midstream;
        ready_in_0 = 1'b0;
        ready_in_1 = 1'b0;
        drive(1'b1, 8'h11, 1'b0);
        cyc();
        drive(1'b1, 8'h22, 1'b1);
        cyc();
        drive(1'b0, 8'h00, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({ready_out, valid_out_0, valid_out_1, data_out_0, data_out_1, cnt_0, cnt_1} !== '0)
            $display("FAIL rst_async: got rdy=%b v=%b%b d=%h/%h c=%h/%h expected all 0",
                     ready_out, valid_out_0, valid_out_1, data_out_0, data_out_1, cnt_0, cnt_1);
        else n_pass++;
        cyc(2);
        ready_in_0 = 1'b1;
        ready_in_1 = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ready_out !== 1'b1) $display("FAIL rst_release: got rdy=%b expected 1", ready_out);
        else n_pass++;
    endtask

    task automatic test_wrap;
        alt_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0);
            cyc();
        end
        drive(1'b0, 8'h00, 1'b0);
        cyc(2);
        n_checks++;
        if ({cnt_0, cnt_1} !== {4'd1, 4'd0})
            $display("FAIL wrap_cnt: got %0d/%0d expected 1/0", cnt_0, cnt_1);
        else n_pass++;
    endtask

    task automatic test_no_loss;
        cyc(2);
        n_checks++;
        if (q0.size() + q1.size() != 0)
            $display("FAIL no_loss: got %0d/%0d undelivered words expected 0/0", q0.size(), q1.size());
        else n_pass++;
    endtask

    initial begin
        test_reset_por();
        test_external();
        test_alternating();
        test_backpressure();
        test_independent();
        test_reset_midstream();
        test_wrap();
        test_no_loss();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
